// File: rtl/car_motion_if.sv
// Bus between the request register (master) and the car motion controller (slave).
// The master posts request bits and time base; the car reports position and services.
interface car_motion_if #(
  parameter int unsigned N_FLOORS = 4,
  parameter int unsigned FLOOR_W  = 2
);
  logic                tick;
  logic [N_FLOORS-1:0] req_pending;
  logic                door_hold;
  logic [FLOOR_W-1:0]  cur_floor;
  logic                moving;
  logic                dir_up;
  logic                door_open;
  logic                serviced_valid;
  logic [FLOOR_W-1:0]  serviced_floor;

  modport master (
    output tick, req_pending, door_hold,
    input  cur_floor, moving, dir_up, door_open, serviced_valid, serviced_floor
  );

  modport slave (
    input  tick, req_pending, door_hold,
    output cur_floor, moving, dir_up, door_open, serviced_valid, serviced_floor
  );
endinterface

// File: rtl/car_motion_controller.sv
// Car-side elevator controller: moves floor by floor toward pending requests,
// opens the door at requested floors and pulses serviced_valid on each service.
module car_motion_controller #(
  parameter int unsigned N_FLOORS     = 4,
  parameter int unsigned FLOOR_W      = 2,
  parameter int unsigned TRAVEL_TICKS = 3,
  parameter int unsigned DOOR_TICKS   = 2
) (
  input  logic       clk,
  input  logic       reset,
  car_motion_if.slave bus
);

  localparam int unsigned TRAVEL_W = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
  localparam int unsigned DOOR_W   = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_TICKS - 1);
  localparam logic [DOOR_W-1:0]   DOOR_LAST   = DOOR_W'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  state_t               state_q, state_n;
  logic [FLOOR_W-1:0]   cur_floor_q, cur_floor_n;
  logic                 dir_up_q, dir_up_n;
  logic [TRAVEL_W-1:0]  travel_cnt_q, travel_cnt_n;
  logic [DOOR_W-1:0]    door_cnt_q, door_cnt_n;
  logic                 moving_q, moving_n;
  logic                 door_open_q, door_open_n;
  logic                 serviced_valid_q, serviced_valid_n;
  logic [FLOOR_W-1:0]   serviced_floor_q, serviced_floor_n;
  logic [FLOOR_W-1:0]   floor_up, floor_dn;

  // Request classification relative to an arbitrary floor
  function automatic logic req_here(input logic [N_FLOORS-1:0] req, input logic [FLOOR_W-1:0] fl);
    logic hit;
    hit = 1'b0;
    for (int unsigned f = 0; f < N_FLOORS; f++)
      if (req[f] && (f == 32'(fl))) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic req_above(input logic [N_FLOORS-1:0] req, input logic [FLOOR_W-1:0] fl);
    logic hit;
    hit = 1'b0;
    for (int unsigned f = 0; f < N_FLOORS; f++)
      if (req[f] && (f > 32'(fl))) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic req_below(input logic [N_FLOORS-1:0] req, input logic [FLOOR_W-1:0] fl);
    logic hit;
    hit = 1'b0;
    for (int unsigned f = 0; f < N_FLOORS; f++)
      if (req[f] && (f < 32'(fl))) hit = 1'b1;
    return hit;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      cur_floor_q      <= '0;
      dir_up_q         <= 1'b1;
      travel_cnt_q     <= '0;
      door_cnt_q       <= '0;
      moving_q         <= 1'b0;
      door_open_q      <= 1'b0;
      serviced_valid_q <= 1'b0;
      serviced_floor_q <= '0;
    end else begin
      state_q          <= state_n;
      cur_floor_q      <= cur_floor_n;
      dir_up_q         <= dir_up_n;
      travel_cnt_q     <= travel_cnt_n;
      door_cnt_q       <= door_cnt_n;
      moving_q         <= moving_n;
      door_open_q      <= door_open_n;
      serviced_valid_q <= serviced_valid_n;
      serviced_floor_q <= serviced_floor_n;
    end
  end

  // Next state; outputs are derived from the next state so they register with it
  always_comb begin
    state_n          = state_q;
    cur_floor_n      = cur_floor_q;
    dir_up_n         = dir_up_q;
    travel_cnt_n     = travel_cnt_q;
    door_cnt_n       = door_cnt_q;
    serviced_valid_n = 1'b0;
    serviced_floor_n = serviced_floor_q;
    floor_up         = cur_floor_q + FLOOR_W'(1);
    floor_dn         = cur_floor_q - FLOOR_W'(1);

    case (state_q)
      IDLE: begin
        if (req_here(bus.req_pending, cur_floor_q)) begin
          state_n          = DOOR_OPEN;
          serviced_valid_n = 1'b1;
          serviced_floor_n = cur_floor_q;
          door_cnt_n       = '0;
        end else if (dir_up_q && req_above(bus.req_pending, cur_floor_q)) begin
          state_n      = MOVE_UP;
          travel_cnt_n = '0;
        end else if (!dir_up_q && req_below(bus.req_pending, cur_floor_q)) begin
          state_n      = MOVE_DOWN;
          travel_cnt_n = '0;
        end else if (req_above(bus.req_pending, cur_floor_q)) begin
          state_n      = MOVE_UP;
          dir_up_n     = 1'b1;
          travel_cnt_n = '0;
        end else if (req_below(bus.req_pending, cur_floor_q)) begin
          state_n      = MOVE_DOWN;
          dir_up_n     = 1'b0;
          travel_cnt_n = '0;
        end
      end
      MOVE_UP: begin
        if (bus.tick) begin
          if (travel_cnt_q == TRAVEL_LAST) begin
            cur_floor_n  = floor_up;
            travel_cnt_n = '0;
            if (req_here(bus.req_pending, floor_up)) begin
              state_n          = DOOR_OPEN;
              serviced_valid_n = 1'b1;
              serviced_floor_n = floor_up;
              door_cnt_n       = '0;
            end else if (!req_above(bus.req_pending, floor_up)) begin
              state_n = IDLE;
            end
          end else begin
            travel_cnt_n = travel_cnt_q + TRAVEL_W'(1);
          end
        end
      end
      MOVE_DOWN: begin
        if (bus.tick) begin
          if (travel_cnt_q == TRAVEL_LAST) begin
            cur_floor_n  = floor_dn;
            travel_cnt_n = '0;
            if (req_here(bus.req_pending, floor_dn)) begin
              state_n          = DOOR_OPEN;
              serviced_valid_n = 1'b1;
              serviced_floor_n = floor_dn;
              door_cnt_n       = '0;
            end else if (!req_below(bus.req_pending, floor_dn)) begin
              state_n = IDLE;
            end
          end else begin
            travel_cnt_n = travel_cnt_q + TRAVEL_W'(1);
          end
        end
      end
      DOOR_OPEN: begin
        // Hold button restarts the timer even on a tick cycle
        if (bus.door_hold) begin
          door_cnt_n = '0;
        end else if (bus.tick) begin
          if (door_cnt_q == DOOR_LAST) begin
            door_cnt_n = '0;
            state_n    = IDLE;
          end else begin
            door_cnt_n = door_cnt_q + DOOR_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    moving_n    = (state_n == MOVE_UP) || (state_n == MOVE_DOWN);
    door_open_n = (state_n == DOOR_OPEN);
  end

  assign bus.cur_floor      = cur_floor_q;
  assign bus.moving         = moving_q;
  assign bus.dir_up         = dir_up_q;
  assign bus.door_open      = door_open_q;
  assign bus.serviced_valid = serviced_valid_q;
  assign bus.serviced_floor = serviced_floor_q;

endmodule

// File: tb/tb_car_motion_controller.sv
// Directed bench for car_motion_controller: a per-cycle vector table for the
// basic service/travel flow, then hand-written multi-cycle corner sequences.
module tb_car_motion_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] req;
  logic       hold;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  int base_pulses;

  car_motion_if #(.N_FLOORS(4), .FLOOR_W(2)) bus ();

  assign bus.tick        = tick;
  assign bus.req_pending = req;
  assign bus.door_hold   = hold;

  car_motion_controller #(
    .N_FLOORS(4), .FLOOR_W(2), .TRAVEL_TICKS(3), .DOOR_TICKS(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] set;
    logic       hold;
    logic [1:0] cur;
    logic       mv;
    logic       up;
    logic       door;
    logic       sv;
    logic [1:0] sf;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock; the request side clears a floor's bit after seeing its pulse
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (bus.serviced_valid) begin
      n_pulses++;
      req[bus.serviced_floor] = 1'b0;
    end
  endtask

  function automatic logic [31:0] obs();
    return 32'({bus.cur_floor, bus.moving, bus.dir_up, bus.door_open,
                bus.serviced_valid, bus.serviced_floor});
  endfunction

  task automatic wait_pulse(input string name, input logic [1:0] fl, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      step();
      if (bus.serviced_valid) seen = 1'b1;
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
    if (seen) check(name, 32'({bus.serviced_floor, bus.door_open}), 32'({fl, 1'b1}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    //            set     hold  cur   mv    up    door  sv    sf
    vecs[0]  = '{4'b0001, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0};
    vecs[1]  = '{4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[2]  = '{4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{4'b1000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[5]  = '{4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[6]  = '{4'b0000, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[7]  = '{4'b0000, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[8]  = '{4'b0000, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[9]  = '{4'b0000, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[10] = '{4'b0000, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[11] = '{4'b0000, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[12] = '{4'b0000, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3};
    vecs[13] = '{4'b0000, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3};
    vecs[14] = '{4'b0000, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3};

    reset = 1'b1;
    tick  = 1'b1;
    req   = 4'b0000;
    hold  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_values", obs(), 32'b00_0_1_0_0_00);
    reset = 1'b0;
    step();
    check("idle_no_req", obs(), 32'b00_0_1_0_0_00);

    // Service at floor 0, then travel 0 -> 3
    for (int i = 0; i < 15; i++) begin
      req  = req | vecs[i].set;
      hold = vecs[i].hold;
      step();
      check($sformatf("vec%0d", i), obs(),
            32'({vecs[i].cur, vecs[i].mv, vecs[i].up, vecs[i].door, vecs[i].sv, vecs[i].sf}));
    end

    // Reverse from floor 3: stop at 2, then continue down to 0
    req = 4'b0101;
    step();
    check("down_start", 32'({bus.moving, bus.dir_up, bus.cur_floor}), 32'({1'b1, 1'b0, 2'd3}));
    wait_pulse("down_stop2", 2'd2, 20);
    wait_pulse("down_stop0", 2'd0, 30);
    step();
    step();
    check("down_closed", 32'({bus.door_open, bus.moving, bus.cur_floor}), 32'({1'b0, 1'b0, 2'd0}));

    // Door hold keeps the door open; tick=0 freezes the timer
    req = 4'b0001;
    step();
    check("hold_open", 32'({bus.serviced_valid, bus.door_open}), 32'b11);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("hold%0d", i), 32'({bus.door_open, bus.serviced_valid}), 32'b10);
    end
    hold = 1'b0;
    tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("notick%0d", i), 32'(bus.door_open), 32'd1);
    end
    tick = 1'b1;
    step();
    check("hold_close1", 32'(bus.door_open), 32'd1);
    step();
    check("hold_close2", 32'(bus.door_open), 32'd0);

    // Request dropped during travel: car stops at the next floor, no service
    base_pulses = n_pulses;
    req = 4'b0100;
    step();
    check("drop_start", 32'({bus.moving, bus.dir_up}), 32'b11);
    req = 4'b0000;
    step();
    step();
    check("drop_mid", 32'({bus.cur_floor, bus.moving}), 32'({2'd0, 1'b1}));
    step();
    check("drop_stop", 32'({bus.cur_floor, bus.moving, bus.door_open}), 32'({2'd1, 1'b0, 1'b0}));
    step();
    check("drop_idle", 32'({bus.cur_floor, bus.moving}), 32'({2'd1, 1'b0}));
    check("drop_no_pulse", 32'(n_pulses - base_pulses), 32'd0);

    // Asynchronous reset between floors 1 and 2
    req = 4'b1000;
    step();
    step();
    check("pre_reset_move", 32'({bus.moving, bus.cur_floor}), 32'({1'b1, 2'd1}));
    #2 reset = 1'b1;
    #1;
    check("async_reset", obs(), 32'b00_0_1_0_0_00);
    req = 4'b0000;
    base_pulses = n_pulses;
    step();
    check("reset_hold", obs(), 32'b00_0_1_0_0_00);
    reset = 1'b0;
    step();
    check("reset_no_pulse", 32'(n_pulses - base_pulses), 32'd0);

    // All floors requested: serviced in ascending order, one pulse each
    base_pulses = n_pulses;
    req = 4'b1111;
    wait_pulse("all_f0", 2'd0, 20);
    wait_pulse("all_f1", 2'd1, 20);
    wait_pulse("all_f2", 2'd2, 20);
    wait_pulse("all_f3", 2'd3, 20);
    for (int i = 0; i < 8; i++) step();
    check("all_pulses", 32'(n_pulses - base_pulses), 32'd4);
    check("all_final", 32'({bus.cur_floor, bus.moving, bus.door_open}), 32'({2'd3, 1'b0, 1'b0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
